// File: rtl/timer_pkg.sv
// Shared encodings and constants for the countdown timer controller.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] MAX_BCD      = 4'd9;

  // Preset layout: {min, sec_tens, sec_ones}, one BCD digit per field
  localparam int DIGIT_W      = 4;
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_LSB      = 8;

endpackage

// File: rtl/bcd_preset_reg.sv
// Three-digit keypad shift register: filters non-BCD codes, drops the oldest
// digit on each new key and flags whether the value is a usable preset.
module bcd_preset_reg
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_clr,
  input  logic        shift_en,
  input  logic [3:0]  digit,
  output logic [11:0] preset,
  output logic        digit_ok,
  output logic        valid
);

  logic [11:0] preset_reg;

  assign digit_ok = (digit <= MAX_BCD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_reg <= '0;
    end else if (sync_clr) begin
      preset_reg <= '0;
    end else if (shift_en && digit_ok) begin
      preset_reg <= {preset_reg[MIN_LSB-1:SEC_ONES_LSB], digit};
    end
  end

  assign preset = preset_reg;
  assign valid  = (preset_reg != '0) &&
                  (preset_reg[SEC_TENS_LSB +: DIGIT_W] <= MAX_SEC_TENS);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer control FSM: keypad preset entry, load/run/pause/clear of the
// BCD chain. Optional alarm hold of `done` when TIMER_ALARM_EN is defined.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_CYCLES = 8
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  input  logic        cnt_zero,
  output logic [11:0] preset,
  output logic        cnt_load,
  output logic        cnt_en,
  output logic        cnt_clearn,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state_o
);

  state_t state_reg, state_next;
  logic   clr_req, shift_en, digit_ok, preset_valid;
  logic   alarm_last, early_exit;
  logic   cnt_load_reg, cnt_clearn_reg, mag_on_reg, done_reg;

  bcd_preset_reg u_preset (
    .clk      (clk),
    .rst      (clear),
    .sync_clr (clr_req),
    .shift_en (shift_en),
    .digit    (key_digit),
    .preset   (preset),
    .digit_ok (digit_ok),
    .valid    (preset_valid)
  );

  always_comb begin
    state_next = state_reg;
    clr_req    = 1'b0;
    shift_en   = 1'b0;
    case (state_reg)
      IDLE, ENTRY: begin
        if (stop_clear) begin
          clr_req    = 1'b1;
          state_next = IDLE;
        end else if (start && door_closed && preset_valid) begin
          state_next = LOAD;
        end else if (key_valid) begin
          shift_en = 1'b1;
          if (digit_ok) state_next = ENTRY;
        end
      end
      LOAD: begin
        if (stop_clear) begin
          clr_req    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop_clear || !door_closed) state_next = PAUSE;
        else if (cnt_zero)              state_next = DONE;
      end
      PAUSE: begin
        if (stop_clear) begin
          clr_req    = 1'b1;
          state_next = IDLE;
        end else if (start && door_closed) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (alarm_last || early_exit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg      <= IDLE;
      cnt_load_reg   <= 1'b0;
      cnt_clearn_reg <= 1'b0;
      mag_on_reg     <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_load_reg   <= (state_next == LOAD);
      cnt_clearn_reg <= !clr_req;
      mag_on_reg     <= (state_next == RUN);
      done_reg       <= (state_next == DONE);
    end
  end

`ifdef TIMER_ALARM_EN
  localparam int ALARM_W = $clog2(ALARM_CYCLES + 1);
  logic [ALARM_W-1:0] alarm_cnt_reg;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      alarm_cnt_reg <= '0;
    end else if (state_reg != DONE) begin
      alarm_cnt_reg <= ALARM_W'(ALARM_CYCLES - 1);
    end else if (alarm_cnt_reg != '0) begin
      alarm_cnt_reg <= alarm_cnt_reg - 1'b1;
    end
  end

  assign alarm_last = (alarm_cnt_reg == '0);
  assign early_exit = stop_clear | key_valid;
`else
  // Pulse build: DONE always lasts one cycle, the alarm length is irrelevant
  assign alarm_last = (ALARM_CYCLES >= 0);
  assign early_exit = 1'b0;
`endif

  // A tick coinciding with a pause request must not reach the chain
  assign cnt_en     = (state_reg == RUN) & tick & door_closed & !stop_clear;
  assign cnt_load   = cnt_load_reg;
  assign cnt_clearn = cnt_clearn_reg;
  assign mag_on     = mag_on_reg;
  assign done       = done_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with a behavioural model of the BCD chain.
module tb_timer_ctrl;

  localparam int ALARM_N = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_LOAD = 3'd2,
                         S_RUN = 3'd3, S_PAUSE = 3'd4, S_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop_clear = 1'b0;
  logic        door_closed = 1'b1;
  logic [3:0]  key_digit = 4'd0;
  logic        cnt_zero;
  logic [11:0] preset;
  logic        cnt_load, cnt_en, cnt_clearn, mag_on, done;
  logic [2:0]  state_o;
  logic [11:0] chain = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [11:0] pre;
    logic        en;
    logic        clrn;
  } exp_t;
  exp_t sb[$];

  timer_ctrl #(.ALARM_CYCLES(ALARM_N)) dut (
    .clk         (clk),
    .clear       (clear),
    .tick        (tick),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .cnt_zero    (cnt_zero),
    .preset      (preset),
    .cnt_load    (cnt_load),
    .cnt_en      (cnt_en),
    .cnt_clearn  (cnt_clearn),
    .mag_on      (mag_on),
    .done        (done),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // External BCD countdown chain (min:sec-tens:sec-ones)
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4]  = 4'd5;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!cnt_clearn)   chain <= 12'h000;
    else if (cnt_load) chain <= preset;
    else if (cnt_en)   chain <= bcd_dec(chain);
  end
  assign cnt_zero = (chain == 12'h000);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show during it
  task automatic drv(input string tag, input bit tk, input bit kv, input logic [3:0] kd,
                     input bit st, input bit sc, input bit dc,
                     input logic [2:0] es, input logic [11:0] ep, input bit een, input bit ecl);
    exp_t e;
    tick = tk; key_valid = kv; key_digit = kd; start = st; stop_clear = sc; door_closed = dc;
    e.tag = tag; e.st = es; e.pre = ep; e.en = een; e.clrn = ecl;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("[%0t] %s state=%0d preset=%h en=%b clrn=%b load=%b mag=%b done=%b chain=%h",
               $time, e.tag, state_o, preset, cnt_en, cnt_clearn, cnt_load, mag_on, done, chain);
      check_eq({e.tag, ".state"},  32'(state_o),    32'(e.st));
      check_eq({e.tag, ".preset"}, 32'(preset),     32'(e.pre));
      check_eq({e.tag, ".cnt_en"}, 32'(cnt_en),     32'(e.en));
      check_eq({e.tag, ".clearn"}, 32'(cnt_clearn), 32'(e.clrn));
      check_eq({e.tag, ".load"},   32'(cnt_load),   32'(e.st == S_LOAD));
      check_eq({e.tag, ".mag_on"}, 32'(mag_on),     32'(e.st == S_RUN));
      check_eq({e.tag, ".done"},   32'(done),       32'(e.st == S_DONE));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.state",  32'(state_o), 32'(S_IDLE));
    check_eq("rst.preset", 32'(preset), 32'h0);
    check_eq("rst.clearn", 32'(cnt_clearn), 32'h0);
    check_eq("rst.mag_on", 32'(mag_on), 32'h0);
    check_eq("rst.done",   32'(done), 32'h0);
    check_eq("rst.load",   32'(cnt_load), 32'h0);
    clear = 1'b0;

    // 1: entry 1,3,0 and run; cnt_en follows tick, LOAD ignores tick/cnt_zero
    drv("t1.rel",   0,0,4'd0, 0,0,1, S_IDLE,  12'h000, 0, 0);
    drv("t1.k1",    0,1,4'd1, 0,0,1, S_IDLE,  12'h000, 0, 1);
    drv("t1.k3",    0,1,4'd3, 0,0,1, S_ENTRY, 12'h001, 0, 1);
    drv("t1.k0",    0,1,4'd0, 0,0,1, S_ENTRY, 12'h013, 0, 1);
    drv("t1.start", 0,0,4'd0, 1,0,1, S_ENTRY, 12'h130, 0, 1);
    drv("t1.load",  1,0,4'd0, 0,0,1, S_LOAD,  12'h130, 0, 1);
    drv("t1.run1",  1,0,4'd0, 0,0,1, S_RUN,   12'h130, 1, 1);
    drv("t1.run0",  0,0,4'd0, 0,0,1, S_RUN,   12'h130, 0, 1);
    drv("t1.run2",  1,0,4'd0, 0,0,1, S_RUN,   12'h130, 1, 1);
    check_eq("t1.chain", 32'(chain), 32'h128);
    drv("t1.stop",  1,0,4'd0, 0,1,1, S_RUN,   12'h130, 0, 1);
    drv("t1.clr",   0,0,4'd0, 0,1,1, S_PAUSE, 12'h130, 0, 1);
    drv("t1.idle0", 0,0,4'd0, 0,0,1, S_IDLE,  12'h000, 0, 0);
    drv("t1.idle1", 0,0,4'd0, 0,0,1, S_IDLE,  12'h000, 0, 1);

    // 4: invalid tens digit blocks start, code 12 ignored, oldest digit dropped
    drv("t4.k1",    0,1,4'd1,  0,0,1, S_IDLE,  12'h000, 0, 1);
    drv("t4.k7",    0,1,4'd7,  0,0,1, S_ENTRY, 12'h001, 0, 1);
    drv("t4.k0",    0,1,4'd0,  0,0,1, S_ENTRY, 12'h017, 0, 1);
    drv("t4.start", 0,0,4'd0,  1,0,1, S_ENTRY, 12'h170, 0, 1);
    drv("t4.k12",   0,1,4'd12, 0,0,1, S_ENTRY, 12'h170, 0, 1);
    drv("t4.ka",    0,1,4'd1,  0,0,1, S_ENTRY, 12'h170, 0, 1);
    drv("t4.kb",    0,1,4'd2,  0,0,1, S_ENTRY, 12'h701, 0, 1);
    drv("t4.kc",    0,1,4'd3,  0,0,1, S_ENTRY, 12'h012, 0, 1);
    drv("t4.kd",    0,1,4'd4,  0,0,1, S_ENTRY, 12'h123, 0, 1);
    drv("t4.dopen", 0,0,4'd0,  1,0,0, S_ENTRY, 12'h234, 0, 1);
    drv("t4.clr",   0,0,4'd0,  0,1,1, S_ENTRY, 12'h234, 0, 1);
    drv("t4.idle0", 0,0,4'd0,  0,0,1, S_IDLE,  12'h000, 0, 0);

    // 2: preset 002 counts to zero, DONE width
    drv("t2.k2",    0,1,4'd2, 0,0,1, S_IDLE,  12'h000, 0, 1);
    drv("t2.start", 0,0,4'd0, 1,0,1, S_ENTRY, 12'h002, 0, 1);
    drv("t2.load",  0,0,4'd0, 0,0,1, S_LOAD,  12'h002, 0, 1);
    drv("t2.tick1", 1,0,4'd0, 0,0,1, S_RUN,   12'h002, 1, 1);
    drv("t2.tick2", 1,0,4'd0, 0,0,1, S_RUN,   12'h002, 1, 1);
    check_eq("t2.zero", 32'(cnt_zero), 32'h1);
    drv("t2.zero",  0,0,4'd0, 0,0,1, S_RUN,   12'h002, 0, 1);
    drv("t2.done",  0,0,4'd0, 0,0,1, S_DONE,  12'h002, 0, 1);
`ifdef TIMER_ALARM_EN
    for (int i = 1; i < ALARM_N; i++)
      drv("t2.hold", 0,0,4'd0, 0,0,1, S_DONE, 12'h002, 0, 1);
`endif
    drv("t2.after", 0,0,4'd0, 0,0,1, S_IDLE,  12'h002, 0, 1);

    // 3: door opens with a tick; chain holds; resume without reload
    drv("t3.k5",    0,1,4'd5, 0,0,1, S_IDLE,  12'h002, 0, 1);
    drv("t3.start", 0,0,4'd0, 1,0,1, S_ENTRY, 12'h025, 0, 1);
    drv("t3.load",  0,0,4'd0, 0,0,1, S_LOAD,  12'h025, 0, 1);
    drv("t3.tick",  1,0,4'd0, 0,0,1, S_RUN,   12'h025, 1, 1);
    drv("t3.door",  1,0,4'd0, 0,0,0, S_RUN,   12'h025, 0, 1);
    drv("t3.ptick", 1,0,4'd0, 0,0,0, S_PAUSE, 12'h025, 0, 1);
    check_eq("t3.hold", 32'(chain), 32'h024);
    drv("t3.stdo",  0,0,4'd0, 1,0,0, S_PAUSE, 12'h025, 0, 1);
    drv("t3.resume",0,0,4'd0, 1,0,1, S_PAUSE, 12'h025, 0, 1);
    drv("t3.run",   1,0,4'd0, 0,0,1, S_RUN,   12'h025, 1, 1);
    check_eq("t3.noreload", 32'(chain), 32'h023);

    // 5: stop_clear beats start in PAUSE
    drv("t5.pause", 1,0,4'd0, 0,1,1, S_RUN,   12'h025, 0, 1);
    drv("t5.both",  0,0,4'd0, 1,1,1, S_PAUSE, 12'h025, 0, 1);
    drv("t5.clr0",  0,0,4'd0, 0,0,1, S_IDLE,  12'h000, 0, 0);
    drv("t5.clr1",  0,0,4'd0, 0,0,1, S_IDLE,  12'h000, 0, 1);
    check_eq("t5.chain", 32'(chain), 32'h000);

    // 6: async clear in the middle of RUN
    drv("t6.k9",    0,1,4'd9, 0,0,1, S_IDLE,  12'h000, 0, 1);
    drv("t6.start", 0,0,4'd0, 1,0,1, S_ENTRY, 12'h009, 0, 1);
    drv("t6.load",  0,0,4'd0, 0,0,1, S_LOAD,  12'h009, 0, 1);
    drv("t6.run",   0,0,4'd0, 0,0,1, S_RUN,   12'h009, 0, 1);
    check_eq("t6.pre_mag", 32'(mag_on), 32'h1);
    #2;
    clear = 1'b1;
    #1;
    $display("[%0t] t6.async state=%0d mag=%b clrn=%b", $time, state_o, mag_on, cnt_clearn);
    check_eq("t6.state",  32'(state_o), 32'(S_IDLE));
    check_eq("t6.mag_on", 32'(mag_on), 32'h0);
    check_eq("t6.clearn", 32'(cnt_clearn), 32'h0);
    check_eq("t6.preset", 32'(preset), 32'h0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    check_eq("t6.rel_clrn", 32'(cnt_clearn), 32'h0);
    @(posedge clk);
    #1;
    check_eq("t6.edge_clrn", 32'(cnt_clearn), 32'h1);
    check_eq("t6.edge_state", 32'(state_o), 32'(S_IDLE));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
